// File: rtl/store_drain_unit.sv
// store_drain_unit
// Post-commit store buffer between the store data queue and the data-memory
// write port. Committed stores are captured into a small FIFO and drained in
// order over a req/ack handshake. While a store sits in the FIFO, loads to the
// same address are forwarded its data so they never observe stale memory.
module store_drain_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              drain_almost_full,
    output logic              drain_empty,
    output logic              overflow,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_P = PTR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    // Pointers carry one extra wrap bit so full (count == DEPTH) and empty
    // (count == 0) are distinguishable with the same index bits.
    logic [PTR_W-1:0] head, tail, head_next, tail_next;
    logic [PTR_W-1:0] count, count_next;
    logic [IDX_W-1:0] head_idx, tail_idx, scan_idx;
    logic             push, pop, full;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign count    = tail - head;
    assign full     = (count == DEPTH_P);

    // A pop only happens in REQ, which is only ever entered with an entry
    // buffered, so the head entry is always valid when popped.
    assign pop  = (state == REQ) && mem_ack;
    // A full FIFO can still accept a store when the head leaves the same cycle.
    assign push = in_vld && (!full || pop);

    assign head_next  = head + PTR_W'(pop);
    assign tail_next  = tail + PTR_W'(push);
    assign count_next = tail_next - head_next;

    // State register for the drain handshake FSM.
    always_ff @(posedge clk) begin
        // NOTE: every sequential block uses non-blocking assignments so all
        // registers sample the pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: request as soon as anything is buffered, drop back to
    // IDLE only when the final entry is acknowledged with nothing arriving.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps all paths
        // assigned, so no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE: if ((count != '0) || push) state_next = REQ;
            REQ:  if (pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Head/tail pointers, entry valid bits and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            valid_q  <= '0;
            overflow <= 1'b0;
        end else begin
            head <= head_next;
            tail <= tail_next;
            // Clear before set: when full with a same-cycle pop and push the
            // slot is reused and must end up valid.
            if (pop)  valid_q[head_idx] <= 1'b0;
            if (push) valid_q[tail_idx] <= 1'b1;
            if (in_vld && !push) overflow <= 1'b1;
        end
    end

    // Entry payload storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is deliberately not reset; valid_q alone
        // qualifies entries, so stale contents are never observed.
        if (push) begin
            addr_q[tail_idx] <= in_addr;
            data_q[tail_idx] <= in_data;
        end
    end

    // Store-to-load forwarding: walk from head (oldest) toward tail so the
    // last match, the youngest store, wins. Uses pre-edge state, so an entry
    // popped this cycle still forwards and one pushed this cycle does not.
    always_comb begin
        ld_hit   = 1'b0;
        ld_data  = '0;
        scan_idx = head_idx;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + IDX_W'(i);
            if (valid_q[scan_idx] && (addr_q[scan_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[scan_idx];
            end
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_addr  = addr_q[head_idx];
    assign mem_wdata = data_q[head_idx];

    // Status flags come from registered state only, so the SDQ sees no
    // combinational path from in_vld or mem_ack.
    assign drain_almost_full = (count >= AFULL_P);
    assign drain_empty       = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_store_drain_unit.sv
// tb_store_drain_unit
// Scoreboard bench: each accepted store is queued when driven, and a negedge
// monitor pops and compares it whenever the memory handshake completes.
module tb_store_drain_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        drain_almost_full;
    logic        drain_empty;
    logic        overflow;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;
    int  writes   = 0;

    always #5 clk = ~clk;

    store_drain_unit #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_vld            (in_vld),
        .in_addr           (in_addr),
        .in_data           (in_data),
        .drain_almost_full (drain_almost_full),
        .drain_empty       (drain_empty),
        .overflow          (overflow),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .ld_addr           (ld_addr),
        .ld_hit            (ld_hit),
        .ld_data           (ld_data)
    );

    // Monitor: every completed write must match the oldest expected store.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ack) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h exp none", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL write_order got addr=%h data=%h exp addr=%h data=%h",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_push(input logic [31:0] a, input logic [31:0] d, input bit accept);
        in_vld  = 1'b1;
        in_addr = a;
        in_data = d;
        if (accept) exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; in_addr = '0; in_data = '0; mem_ack = 1'b0; ld_addr = '0;
        repeat (2) next_cycle();
        rst = 1'b0;
        settle();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (drain_empty !== 1'b1) begin failures++; $display("FAIL reset_drain_empty got=%b exp=1", drain_empty); end
        checks++; if (drain_almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", drain_almost_full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin failures++; $display("FAIL reset_ld got hit=%b data=%h exp hit=0 data=0", ld_hit, ld_data); end
    endtask

    task automatic test_single_store();
        mem_ack = 1'b1;
        next_cycle();
        drive_push(32'h100, 32'hDEAD_BEEF, 1'b1);
        settle();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL single_c0_req got=%b exp=0", mem_req); end
        next_cycle();
        in_vld = 1'b0;
        settle();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single_c1_req got req=%b addr=%h data=%h exp req=1 addr=100 data=deadbeef", mem_req, mem_addr, mem_wdata);
        end
        next_cycle();
        settle();
        checks++; if (mem_req !== 1'b0 || drain_empty !== 1'b1) begin
            failures++; $display("FAIL single_c2_idle got req=%b empty=%b exp req=0 empty=1", mem_req, drain_empty);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_stall_fill();
        int w0;
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_push(32'(4 * i), 32'hA000 + 32'(i), 1'b1);
            settle();
            checks++; if (drain_almost_full !== (i >= 3)) begin
                failures++; $display("FAIL fill_almost_full_%0d got=%b exp=%b", i, drain_almost_full, (i >= 3));
            end
            if (i > 0) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
                    failures++; $display("FAIL fill_head_stable_%0d got req=%b addr=%h exp req=1 addr=0", i, mem_req, mem_addr);
                end
            end
        end
        next_cycle();
        in_vld = 1'b0;
        settle();
        checks++; if (drain_almost_full !== 1'b1 || mem_addr !== 32'h0) begin
            failures++; $display("FAIL fill_full got afull=%b addr=%h exp afull=1 addr=0", drain_almost_full, mem_addr);
        end
        w0 = writes;
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            mem_ack = 1'b1;
            settle();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * j)) begin
                failures++; $display("FAIL drain_seq_%0d got req=%b addr=%h exp req=1 addr=%h", j, mem_req, mem_addr, 32'(4 * j));
            end
        end
        next_cycle();
        mem_ack = 1'b0;
        settle();
        checks++; if (mem_req !== 1'b0 || drain_empty !== 1'b1 || (writes - w0) != 4) begin
            failures++; $display("FAIL drain_done got req=%b empty=%b writes=%0d exp req=0 empty=1 writes=4", mem_req, drain_empty, writes - w0);
        end
    endtask

    task automatic test_overflow();
        int w0;
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_push(32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
        end
        next_cycle();
        drive_push(32'h210, 32'hBAD, 1'b0);
        next_cycle();
        in_vld  = 1'b0;
        ld_addr = 32'h210;
        settle();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (ld_hit !== 1'b0 || mem_addr !== 32'h200 || drain_almost_full !== 1'b1) begin
            failures++; $display("FAIL ovf_unchanged got hit=%b addr=%h afull=%b exp hit=0 addr=200 afull=1", ld_hit, mem_addr, drain_almost_full);
        end
        repeat (3) next_cycle();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        w0 = writes;
        mem_ack = 1'b1;
        repeat (6) next_cycle();
        settle();
        checks++; if ((writes - w0) != 4 || drain_empty !== 1'b1 || overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_drain got writes=%0d empty=%b ovf=%b exp writes=4 empty=1 ovf=1", writes - w0, drain_empty, overflow);
        end
        mem_ack = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        settle();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_reset got=%b exp=0", overflow); end

        // Full FIFO with a same-cycle pop accepts the incoming store.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_push(32'h220 + 32'(4 * i), 32'hC0 + 32'(i), 1'b1);
        end
        w0 = writes;
        next_cycle();
        mem_ack = 1'b1;
        drive_push(32'h230, 32'hC5, 1'b1);
        next_cycle();
        in_vld = 1'b0;
        settle();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pop_push got=%b exp=0", overflow); end
        repeat (6) next_cycle();
        settle();
        checks++; if ((writes - w0) != 5 || overflow !== 1'b0 || drain_empty !== 1'b1) begin
            failures++; $display("FAIL ovf_pop_push_drain got writes=%0d ovf=%b empty=%b exp writes=5 ovf=0 empty=1", writes - w0, overflow, drain_empty);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_forwarding();
        mem_ack = 1'b0;
        next_cycle();
        drive_push(32'h40, 32'h11, 1'b1);
        next_cycle();
        drive_push(32'h40, 32'h22, 1'b1);
        next_cycle();
        drive_push(32'h80, 32'h33, 1'b1);
        ld_addr = 32'h80;
        settle();
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
            failures++; $display("FAIL fwd_same_cycle_push got hit=%b data=%h exp hit=0 data=0", ld_hit, ld_data);
        end
        next_cycle();
        in_vld  = 1'b0;
        ld_addr = 32'h40;
        settle();
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22) begin
            failures++; $display("FAIL fwd_youngest got hit=%b data=%h exp hit=1 data=22", ld_hit, ld_data);
        end
        ld_addr = 32'h44;
        settle();
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
            failures++; $display("FAIL fwd_miss got hit=%b data=%h exp hit=0 data=0", ld_hit, ld_data);
        end
        ld_addr = 32'h80;
        settle();
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h33) begin
            failures++; $display("FAIL fwd_tail got hit=%b data=%h exp hit=1 data=33", ld_hit, ld_data);
        end
        next_cycle();
        mem_ack = 1'b1;
        ld_addr = 32'h40;
        settle();
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22) begin
            failures++; $display("FAIL fwd_pop_oldest got hit=%b data=%h exp hit=1 data=22", ld_hit, ld_data);
        end
        next_cycle();
        settle();
        checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22) begin
            failures++; $display("FAIL fwd_popping_head got hit=%b data=%h exp hit=1 data=22", ld_hit, ld_data);
        end
        next_cycle();
        settle();
        checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
            failures++; $display("FAIL fwd_after_pop got hit=%b data=%h exp hit=0 data=0", ld_hit, ld_data);
        end
        next_cycle();
        mem_ack = 1'b0;
        settle();
        checks++; if (drain_empty !== 1'b1) begin failures++; $display("FAIL fwd_drained got=%b exp=1", drain_empty); end
    endtask

    task automatic test_wrap_random();
        int pushed = 0;
        int cycles = 0;
        int w0;
        w0 = writes;
        while ((pushed < 10 || exp_q.size() != 0) && cycles < 400) begin
            next_cycle();
            cycles++;
            in_vld  = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
            checks++; if (drain_empty !== (exp_q.size() == 0)) begin
                failures++; $display("FAIL wrap_empty_c%0d got=%b exp=%b", cycles, drain_empty, (exp_q.size() == 0));
            end
            if (pushed < 10 && exp_q.size() < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
                drive_push(32'h1000 + 32'(4 * pushed), $urandom, 1'b1);
                pushed++;
            end
        end
        checks++; if (cycles >= 400) begin
            failures++; $display("FAIL wrap_timeout got pending=%0d pushed=%0d exp pending=0 pushed=10", exp_q.size(), pushed);
        end
        next_cycle();
        in_vld  = 1'b0;
        mem_ack = 1'b0;
        settle();
        checks++; if (drain_empty !== 1'b1 || (writes - w0) != 10) begin
            failures++; $display("FAIL wrap_done got empty=%b writes=%0d exp empty=1 writes=10", drain_empty, writes - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_push(32'h300 + 32'(4 * i), 32'hD0 + 32'(i), 1'b1);
        end
        next_cycle();
        in_vld  = 1'b0;
        ld_addr = 32'h304;
        settle();
        checks++; if (mem_req !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 32'hD1) begin
            failures++; $display("FAIL rstmid_pre got req=%b hit=%b data=%h exp req=1 hit=1 data=d1", mem_req, ld_hit, ld_data);
        end
        next_cycle();
        rst = 1'b1;
        exp_q.delete();
        next_cycle();
        rst = 1'b0;
        settle();
        checks++; if (mem_req !== 1'b0 || drain_empty !== 1'b1 || drain_almost_full !== 1'b0) begin
            failures++; $display("FAIL rstmid_state got req=%b empty=%b afull=%b exp req=0 empty=1 afull=0", mem_req, drain_empty, drain_almost_full);
        end
        for (int i = 0; i < 3; i++) begin
            ld_addr = 32'h300 + 32'(4 * i);
            settle();
            checks++; if (ld_hit !== 1'b0) begin
                failures++; $display("FAIL rstmid_ld_%0d got hit=%b exp hit=0", i, ld_hit);
            end
        end
        // An ack while idle must not start or complete any write.
        w0 = writes;
        mem_ack = 1'b1;
        repeat (3) next_cycle();
        checks++; if (writes != w0 || mem_req !== 1'b0 || drain_empty !== 1'b1) begin
            failures++; $display("FAIL idle_ack got writes=%0d req=%b empty=%b exp writes=0 req=0 empty=1", writes - w0, mem_req, drain_empty);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_stall_fill();
        test_overflow();
        test_forwarding();
        test_wrap_random();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/store_drain_unit.md
# store_drain_unit

Post-commit store buffer that sits directly downstream of the store data queue (SDQ). It captures each committed store the SDQ issues (address and data) into a small FIFO, then drains the FIFO in order to the data-memory write port over a req/ack handshake. While stores are in the FIFO it provides store-to-load forwarding, so a load cannot read stale memory for a store that has left the SDQ but has not yet been written.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: address width.
- DATA_W, 32: store data width (whole-word stores only).

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_vld  in  1  SDQ issue valid (issue_vld).
- in_addr  in  ADDR_W  store address from the SDQ issue entry.
- in_data  in  DATA_W  store data from the SDQ issue entry.
- drain_almost_full  out  1  backpressure to the SDQ; high when count >= DEPTH-1.
- drain_empty  out  1  high when count == 0 and no request is in progress (used for fences).
- overflow  out  1  sticky error; set when a push is dropped.
- mem_req  out  1  write request to data memory.
- mem_addr  out  ADDR_W  write address (head entry).
- mem_wdata  out  DATA_W  write data (head entry).
- mem_ack  in  1  memory accepted the write this cycle.
- ld_addr  in  ADDR_W  load lookup address.
- ld_hit  out  1  some buffered entry matches ld_addr.
- ld_data  out  DATA_W  data of the youngest matching entry; 0 when there is no hit.

## Operation
- Storage:
  - DEPTH entries of {addr, data, valid}.
  - Head and tail pointers are log2(DEPTH)+1 bits wide, with wrap-bit full/empty detection.
  - count = tail - head, modulo 2^(log2(DEPTH)+1).
- Push: a push occurs when in_vld is high and either count < DEPTH or a pop happens in the same cycle.
  - The push writes entry[tail] and increments tail.
  - When in_vld is high, count == DEPTH and there is no pop, the store is dropped, overflow is set, and the FIFO is unchanged.
- FSM states are IDLE and REQ.
  - IDLE: mem_req = 0. Move to REQ at the next edge if count > 0 or a push occurs this cycle.
  - REQ: mem_req = 1, mem_addr/mem_wdata = entry[head]. These must stay stable until mem_ack.
  - On mem_ack in REQ: pop (clear valid[head], increment head). Stay in REQ if the post-edge count > 0, counting any same-cycle push; otherwise go to IDLE.
  - mem_ack outside REQ is ignored.
- Forwarding (combinational):
  - Scan all valid entries from head toward tail. The last match, i.e. the youngest, drives ld_data.
  - The head entry being popped this cycle still participates in the scan.
  - A store being pushed this cycle does not participate.
- Pointers wrap modulo DEPTH for indexing. The wrap bit distinguishes full from empty.
- Reset:
  - head = tail = 0, all valid bits = 0, state = IDLE, overflow = 0.
  - Output values after reset: mem_req 0, drain_empty 1, drain_almost_full 0, ld_hit 0, ld_data 0.
  - mem_addr/mem_wdata are don't-care while mem_req = 0.
  - Reset during REQ abandons the pending write with no further handshake.

## Timing
- Push to request latency: in_vld at cycle N gives mem_req = 1 at N+1 with that store's address and data, when the FIFO was empty and the FSM was in IDLE.
- Back-to-back draining: mem_ack at cycle M with count > 1 gives mem_req at M+1 carrying the next entry. The throughput is one store per cycle when mem_ack is held high.
- drain_almost_full and drain_empty are derived from registered state, so they have no combinational path from in_vld or mem_ack.
  - The SDQ's one-cycle-registered issue therefore leaves one slot of slack.
- A simultaneous push and pop leaves count unchanged.
- ld_hit/ld_data are valid in the same cycle as ld_addr.

## Test plan
- Single store, mem_ack tied to 1:
  - Stimulus: push addr 0x100, data 0xDEADBEEF at cycle 0.
  - Required: mem_req = 1 at cycle 1 with 0x100/0xDEADBEEF. Back to IDLE at cycle 2. drain_empty = 1 at cycle 2.
- Stall and fill, DEPTH = 4:
  - Stimulus: hold mem_ack = 0 and push 4 stores (addr 0x0, 0x4, 0x8, 0xC). Then release mem_ack.
  - Required: drain_almost_full rises after the 3rd push. mem_addr stays 0x0 until ack, then drains 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Overflow:
  - Stimulus: with the FIFO full and mem_ack = 0, push a 5th store.
  - Required: overflow = 1 and stays high. Contents unchanged. Exactly 4 writes occur after ack.
  - Repeat with mem_ack = 1 on the same cycle: the 5th store is accepted and overflow stays 0.
- Forwarding priority:
  - Stimulus: with mem_ack = 0, buffer 0x40 = 0x11 then 0x40 = 0x22. Set ld_addr = 0x40.
  - Required: ld_hit = 1, ld_data = 0x22.
  - ld_addr = 0x44 gives ld_hit = 0, ld_data = 0.
- Wrap-around: push and drain 10 stores with random ack gaps.
  - Required: write order and data match the push order exactly.
  - drain_empty = 1 only after the final ack.
- Reset mid-operation:
  - Stimulus: assert rst while in REQ with 3 entries buffered.
  - Required: next cycle mem_req = 0, drain_empty = 1, ld_hit = 0 for all prior addresses.
